// File: rtl/seg7_pkg.sv
// Shared glyph constants for the 7-segment scan driver.
// Segment order inside a glyph is {a,b,c,d,e,f,g}; a is the MSB.
package seg7_pkg;

    // Index into the glyph set: one hex nibble.
    typedef logic [3:0] glyph_idx_t;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_A    = 7'b1110111;
    localparam logic [6:0] SEG_B    = 7'b0011111;
    localparam logic [6:0] SEG_C    = 7'b1001110;
    localparam logic [6:0] SEG_D    = 7'b0111101;
    localparam logic [6:0] SEG_E    = 7'b1001111;
    localparam logic [6:0] SEG_F    = 7'b1000111;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational nibble-to-glyph decoder. Values 10..15 render as letters in
// hex mode and as a dash in BCD mode. Output is active-high {a..g}.
module hex7seg_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] seg
);

    // Map one nibble to its segment pattern.
    always_comb begin
        // NOTE: a default assigned first covers every path through the case,
        // so no latch is inferred for seg.
        seg = SEG_DASH;
        case (glyph_idx_t'(nibble))
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = hex_mode ? SEG_A : SEG_DASH;
            4'hB: seg = hex_mode ? SEG_B : SEG_DASH;
            4'hC: seg = hex_mode ? SEG_C : SEG_DASH;
            4'hD: seg = hex_mode ? SEG_D : SEG_DASH;
            4'hE: seg = hex_mode ? SEG_E : SEG_DASH;
            4'hF: seg = hex_mode ? SEG_F : SEG_DASH;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for NDIGITS 7-segment digits on a shared segment bus.
// A pending register collects loads during a frame; it is copied to the display
// register when the digit index wraps, so a frame never mixes old and new values.
// Each slot opens with BLANK_CYC dark clocks to stop ghosting between digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NDIGITS    = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic                   en,
    input  logic                   hex_mode,
    input  logic                   lzb_en,
    output logic [7:0]             seg_o,
    output logic [NDIGITS-1:0]     an_o,
    output logic                   frame_done
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    // Inactive output levels depend on the board polarity.
    localparam logic [NDIGITS-1:0] AN_OFF  = {NDIGITS{ACTIVE_LOW != 0}};
    localparam logic [7:0]         SEG_IDL = {8{ACTIVE_LOW != 0}};

    // Reject unsupported parameter sets at elaboration.
    if (NDIGITS < 1 || NDIGITS > 16) begin : g_bad_ndigits
        $fatal(1, "seg7_scan_driver: NDIGITS must be 1..16");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $fatal(1, "seg7_scan_driver: SCAN_DIV must be >= 2");
    end
    if (BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_blank_cyc
        $fatal(1, "seg7_scan_driver: BLANK_CYC must be 0..SCAN_DIV-1");
    end

    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*NDIGITS-1:0] pend_q, pend_d;
    logic [NDIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NDIGITS-1:0] disp_q, disp_d;
    logic [NDIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                 frame_done_q, frame_done_d;
    logic [NDIGITS-1:0]   an_q, an_d;
    logic [7:0]           seg_q, seg_d;

    logic                 tick;
    logic                 wrap;
    glyph_idx_t           cur_nibble;
    logic                 cur_dp;
    logic                 cur_lz;
    logic [6:0]           cur_glyph;
    logic                 dark;

    assign tick = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    assign wrap = tick && (idx_q == IDX_W'(NDIGITS - 1));

    // Select the current digit's nibble, decimal point and leading-zero status.
    always_comb begin
        cur_nibble = '0;
        cur_dp     = 1'b0;
        cur_lz     = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nibble = disp_q[4*i +: 4];
                cur_dp     = disp_dp_q[i];
                cur_lz     = (i > 0) && ((disp_q >> (4*i)) == '0) && !disp_dp_q[i];
            end
        end
    end

    hex7seg_dec u_dec (
        .nibble   (cur_nibble),
        .hex_mode (hex_mode),
        .seg      (cur_glyph)
    );

    // Next-state for divider, digit index, frame-aligned load path and outputs.
    always_comb begin
        div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
        idx_d        = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end

        pend_d       = load ? value : pend_q;
        pend_dp_d    = load ? dp_in : pend_dp_q;

        // A load on the wrap edge bypasses pending so it shows immediately.
        disp_d       = disp_q;
        disp_dp_d    = disp_dp_q;
        if (wrap) begin
            disp_d    = load ? value : pend_q;
            disp_dp_d = load ? dp_in : pend_dp_q;
        end

        frame_done_d = wrap;

        dark  = !en || (div_cnt_q < DIV_W'(BLANK_CYC)) || (lzb_en && cur_lz);
        an_d  = dark ? '0 : (NDIGITS'(1) << idx_q);
        seg_d = dark ? '0 : {cur_glyph, cur_dp};
        if (ACTIVE_LOW != 0) begin
            an_d  = ~an_d;
            seg_d = ~seg_d;
        end
    end

    // State register; reset forces all state to zero and the pins dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            div_cnt_q    <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            frame_done_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_IDL;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an_o       = an_q;
    assign seg_o      = seg_q;
    assign frame_done = frame_done_q;

endmodule
